// File: rtl/addsub_serial.sv
// Digit-serial two's-complement adder/subtractor, LSD first, valid/ready on both sides.
// Optional saturation of the result on signed overflow when ADDSUB_SAT_EN is defined.
module addsub_serial #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ctrl,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c,
    output logic             v,
    output logic             z
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             c_q, c_d;
    logic             v_q, v_d;
    logic             z_q, z_d;

    logic [DIGIT:0]   dsum;
    logic [WIDTH-1:0] sr_shift;
    logic [WIDTH-1:0] res;
    logic             cin_msb;
    logic             v_raw;

    // b is stored already inverted for subtract; the +1 rides in on the carry.
    assign dsum = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry_q};

    generate
        if (N == 1) begin : g_single
            assign sr_shift = dsum[DIGIT-1:0];
        end else begin : g_multi
            assign sr_shift = {dsum[DIGIT-1:0], sr_q[WIDTH-1:DIGIT]};
        end
    endgenerate

    // On the top digit, carry into the MSB is recovered from the MSB sum bit.
    assign cin_msb = a_q[DIGIT-1] ^ b_q[DIGIT-1] ^ dsum[DIGIT-1];
    assign v_raw   = cin_msb ^ dsum[DIGIT];

`ifdef ADDSUB_SAT_EN
    assign res = !v_raw          ? sr_shift :
                 sr_shift[WIDTH-1] ? {1'b0, {(WIDTH-1){1'b1}}} :
                                     {1'b1, {(WIDTH-1){1'b0}}};
`else
    assign res = sr_shift;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sr_q    <= '0;
            sum_q   <= '0;
            c_q     <= 1'b0;
            v_q     <= 1'b0;
            z_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sr_q    <= sr_d;
            sum_q   <= sum_d;
            c_q     <= c_d;
            v_q     <= v_d;
            z_q     <= z_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sr_d    = sr_q;
        sum_d   = sum_q;
        c_d     = c_q;
        v_d     = v_q;
        z_d     = z_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b ^ {WIDTH{ctrl}};
                    carry_d = ctrl;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                a_d     = a_q >> DIGIT;
                b_d     = b_q >> DIGIT;
                carry_d = dsum[DIGIT];
                sr_d    = sr_shift;
                if (cnt_q == LAST) begin
                    state_d = S_DONE;
                    sum_d   = res;
                    c_d     = dsum[DIGIT];
                    v_d     = v_raw;
                    z_d     = (res == '0);
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Abort wins over acceptance and completion; published results are kept.
        if (flush) begin
            state_d = S_IDLE;
            sum_d   = sum_q;
            c_d     = c_q;
            v_d     = v_q;
            z_d     = z_q;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign sum       = sum_q;
    assign c         = c_q;
    assign v         = v_q;
    assign z         = z_q;

endmodule

// File: tb/tb_addsub_serial.sv
// Bench for addsub_serial at WIDTH=16, DIGIT=4: directed, random, backpressure and abort scenarios.
// Expected results come from integer arithmetic; ADDSUB_SAT_EN selects the clamped model.
module tb_addsub_serial;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        ctrl;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        c;
    logic        v;
    logic        z;

    int errors = 0;
    int checks = 0;
    logic [15:0] last_sum;

    addsub_serial #(.WIDTH(16), .DIGIT(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .ctrl      (ctrl),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .c         (c),
        .v         (v),
        .z         (z)
    );

    always #5 clk = ~clk;

    // Returns {z, v, c, sum[15:0]}.
    function automatic logic [18:0] model(input logic [15:0] ma, input logic [15:0] mb, input logic mc);
        int sa, sb, ua, ub, ex;
        logic [15:0] s;
        logic mcar, mv;
        sa   = $signed(ma);
        sb   = $signed(mb);
        ua   = ma;
        ub   = mb;
        ex   = mc ? (sa - sb) : (sa + sb);
        mcar = mc ? (ua >= ub) : ((ua + ub) > 65535);
        mv   = (ex > 32767) || (ex < -32768);
        s    = ex[15:0];
`ifdef ADDSUB_SAT_EN
        if (mv) s = (ex > 0) ? 16'h7FFF : 16'h8000;
`endif
        return {(s == 16'h0000), mv, mcar, s};
    endfunction

    task automatic run_op(input logic [15:0] ta, input logic [15:0] tb2, input logic tc, input string nm);
        logic [18:0] e;
        int k;
        e = model(ta, tb2, tc);
        k = 0;
        while (in_ready !== 1'b1 && k < 20) begin @(posedge clk); #1; k++; end
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL %s ready_wait: in_ready=%b want 1", nm, in_ready); end
        a = ta; b = tb2; ctrl = tc; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = 16'($urandom); b = 16'($urandom); ctrl = 1'($urandom);
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL %s accept: in_ready=%b want 0", nm, in_ready); end
        k = 0;
        while (out_valid !== 1'b1 && k < 20) begin @(posedge clk); #1; k++; end
        checks++;
        if (k != 4) begin errors++; $display("FAIL %s latency: got %0d cycles want 4", nm, k); end
        checks++;
        if ({z, v, c, sum} !== e)
        begin
            errors++;
            $display("FAIL %s result: sum=%h c=%b v=%b z=%b want sum=%h c=%b v=%b z=%b",
                     nm, sum, c, v, z, e[15:0], e[16], e[17], e[18]);
        end
        last_sum = e[15:0];
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1)
        begin
            errors++;
            $display("FAIL %s handshake: out_valid=%b in_ready=%b want 0 1", nm, out_valid, in_ready);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = 16'h0; b = 16'h0; ctrl = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({sum, c, v, z, out_valid, in_ready} !== {16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1})
        begin
            errors++;
            $display("FAIL reset: sum=%h c=%b v=%b z=%b out_valid=%b in_ready=%b want 0 0 0 0 0 1",
                     sum, c, v, z, out_valid, in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        run_op(16'h1234, 16'h0FFF, 1'b0, "add_basic");
        run_op(16'h0005, 16'h0005, 1'b1, "sub_zero");
        run_op(16'h0003, 16'h0005, 1'b1, "sub_borrow");
        run_op(16'h7FFF, 16'h0001, 1'b0, "add_pos_ovf");
        run_op(16'h8000, 16'h0001, 1'b1, "sub_neg_ovf");
        run_op(16'h8000, 16'h8000, 1'b0, "add_neg_ovf");
        run_op(16'h0000, 16'h8000, 1'b1, "sub_min");
        run_op(16'hFFFF, 16'h0001, 1'b0, "add_wrap_zero");
    endtask

    task automatic test_random();
        for (int i = 0; i < 25; i++) begin
            run_op(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), $sformatf("rand_%0d", i));
        end
    endtask

    task automatic test_back_to_back();
        logic [18:0] e1, e2;
        int k;
        e1 = model(16'h1234, 16'h0FFF, 1'b0);
        e2 = model(16'h4321, 16'h1111, 1'b1);
        a = 16'h1234; b = 16'h0FFF; ctrl = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        k = 0;
        while (out_valid !== 1'b1 && k < 20) begin @(posedge clk); #1; k++; end
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_done: out_valid=%b want 1", out_valid); end
        a = 16'h4321; b = 16'h1111; ctrl = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++;
            if ({sum, c, v, z, out_valid, in_ready} !== {e1[15:0], e1[16], e1[17], e1[18], 1'b1, 1'b0})
            begin
                errors++;
                $display("FAIL bp_hold_%0d: sum=%h c=%b v=%b z=%b out_valid=%b in_ready=%b want %h %b %b %b 1 0",
                         i, sum, c, v, z, out_valid, in_ready, e1[15:0], e1[16], e1[17], e1[18]);
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1)
        begin
            errors++;
            $display("FAIL bp_release: out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_accept2: in_ready=%b want 0", in_ready); end
        k = 0;
        while (out_valid !== 1'b1 && k < 20) begin @(posedge clk); #1; k++; end
        checks++;
        if (k != 4 || {z, v, c, sum} !== e2)
        begin
            errors++;
            $display("FAIL bp_second: cycles=%0d sum=%h c=%b v=%b z=%b want 4 %h %b %b %b",
                     k, sum, c, v, z, e2[15:0], e2[16], e2[17], e2[18]);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_flush();
        logic seen;
        run_op(16'h1111, 16'h2222, 1'b0, "flush_prev");
        flush = 1'b1; in_valid = 1'b1; a = 16'h0001; b = 16'h0001; ctrl = 1'b0;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_idle_accept: in_ready=%b want 1", in_ready); end
        a = 16'hAAAA; b = 16'h0001; ctrl = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || sum !== last_sum)
        begin
            errors++;
            $display("FAIL flush_run: in_ready=%b out_valid=%b sum=%h want 1 0 %h", in_ready, out_valid, sum, last_sum);
        end
        seen = 1'b0;
        repeat (8) begin @(posedge clk); #1; if (out_valid !== 1'b0) seen = 1'b1; end
        checks++;
        if (seen !== 1'b0) begin errors++; $display("FAIL flush_no_valid: out_valid seen=%b want 0", seen); end
        run_op(16'h1234, 16'h0FFF, 1'b0, "after_flush");
    endtask

    task automatic test_async_reset();
        a = 16'h5555; b = 16'h1234; ctrl = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({sum, c, v, z, out_valid, in_ready} !== {16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1})
        begin
            errors++;
            $display("FAIL async_reset: sum=%h c=%b v=%b z=%b out_valid=%b in_ready=%b want 0 0 0 0 0 1",
                     sum, c, v, z, out_valid, in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_op(16'h1234, 16'h0FFF, 1'b0, "after_reset");
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_flush();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/addsub_serial.md
# addsub_serial

Parametrised, multi-cycle two's-complement adder/subtractor that processes `DIGIT` bits per clock, least-significant digit first. It replaces fixed-width ripple add/sub instances wherever area matters more than latency, and adds a valid/ready handshake, signed-overflow and zero flags, and an optional saturating mode. It sits between an operand source and a result consumer in the datapath.

## Interface
- `WIDTH`, 16: operand and result width in bits. Must be ≥ 2.
- `DIGIT`, 4: bits processed per cycle. Must satisfy `WIDTH % DIGIT == 0`. `N = WIDTH/DIGIT` is the number of RUN cycles.
- `clk` input, 1 bit: clock. All state updates on the rising edge.
- `rst_n` input, 1 bit: reset, asynchronous, active-low.
- `flush` input, 1 bit: synchronous abort.
- `in_valid` input, 1 bit: operands present.
- `in_ready` output, 1 bit: block can accept operands. Equals (state == IDLE).
- `a`, `b` input, `WIDTH` bits: operands.
- `ctrl` input, 1 bit: 0 computes a+b, 1 computes a−b (implemented as a + ~b + 1).
- `out_valid` output, 1 bit: result valid. Equals (state == DONE).
- `out_ready` input, 1 bit: consumer accepts the result.
- `sum` output, `WIDTH` bits: result.
- `c` output, 1 bit: carry out of the MSB. For subtract, 1 means no borrow (a ≥ b unsigned).
- `v` output, 1 bit: signed overflow, computed as carry into MSB XOR carry out of MSB.
- `z` output, 1 bit: 1 when the final `sum` is all zeros.

## Operation
- States are IDLE, RUN and DONE. Reset state is IDLE.
- IDLE:
  - On `in_valid && in_ready`, latch `a`, `b` and `ctrl`.
  - Load the carry register with `ctrl` and clear the digit counter.
  - Go to RUN.
  - Operands may change freely after acceptance.
- RUN:
  - Each cycle adds digit k of `a` to digit k of (`b` XOR {WIDTH{ctrl}}) plus the carry register.
  - Shift the `DIGIT`-bit partial sum into an internal result shift register, MSB side, and store the carry.
  - Record the carry into the MSB when the top digit is processed.
  - After the Nth digit, go to DONE.
- Entering DONE: `sum`, `c`, `v` and `z` are loaded in the same edge and then hold until the next entry into DONE.
- DONE:
  - Hold the outputs.
  - On `out_ready`, go to IDLE.
  - No new operands are accepted in this state, even if `out_ready` is high.
- `flush` high at a rising edge forces the state to IDLE, discards the operation in flight and leaves `sum`, `c`, `v`, `z` unchanged.
  - `flush` has priority over acceptance and completion.
  - If `flush` and `in_valid` are both high in IDLE, nothing is accepted.
- Width rule: all arithmetic is modulo 2^WIDTH. `c` and `v` are the only indication of overflow.

## Timing
- `rst_n` low: state goes to IDLE immediately, regardless of the clock. This holds mid-RUN and in DONE, and the operation in flight is lost.
- Reset values:
  - `sum` = 0, `c` = 0, `v` = 0, `z` = 0, `out_valid` = 0.
  - `in_ready` = 1.
- Latency: if operands are accepted at edge E0, `out_valid` rises after edge EN (N RUN edges). At the defaults this is 4 cycles.
- Throughput: one result every N+2 cycles at best (accept, N RUN, DONE handshake).
- Backpressure: while `out_valid && !out_ready`, all outputs are stable and `in_ready` = 0.
- `out_valid` falls on the edge where `out_ready` is sampled high. `in_ready` rises on that same edge.

## Configuration
- Macro: `ADDSUB_SAT_EN`.
- Defined:
  - On signed overflow (`v` = 1), `sum` is clamped when loaded.
  - Positive overflow gives 0x7FF…F; negative overflow (the MSB of the raw sum is 0) gives 0x800…0.
  - `v` and `c` still report the raw overflow and carry.
  - `z` is computed on the clamped value.
- Undefined: `sum` wraps modulo 2^WIDTH and no clamping logic is generated.

## Test plan
All scenarios use WIDTH=16, DIGIT=4.
- Add, 0x1234 + 0x0FFF, `ctrl`=0 → `sum`=0x2233, `c`=0, `v`=0, `z`=0. `out_valid` rises exactly 4 cycles after the accept edge.
- Subtract, 0x0005 − 0x0005, `ctrl`=1 → `sum`=0x0000, `c`=1, `v`=0, `z`=1. Subtract, 0x0003 − 0x0005 → `sum`=0xFFFE, `c`=0.
- Add, 0x7FFF + 0x0001 → without the macro, `sum`=0x8000, `v`=1, `c`=0. With `ADDSUB_SAT_EN`, `sum`=0x7FFF, `v`=1.
- Subtract, 0x8000 − 0x0001 → without the macro, `sum`=0x7FFF, `v`=1, `c`=1. With `ADDSUB_SAT_EN`, `sum`=0x8000.
- Backpressure: hold `out_ready`=0 for 3 cycles in DONE with `in_valid`=1 and new operands presented.
  - Result and flags stay stable and `in_ready`=0.
  - On `out_ready`=1 → IDLE, then the new operands are accepted and produce the correct result.
- Abort, in three cases:
  - `flush` pulsed after 2 RUN cycles → IDLE next cycle, `out_valid` never asserts, previous `sum` is retained.
  - `rst_n` pulsed low mid-RUN → all outputs equal their reset values.
  - In both cases the next 0x1234 + 0x0FFF completes with 0x2233.
